regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file: the next generation of the 64-bit, 32-entry, 2-read/1-write integer register file in the datapath. Width, depth and read-port count are configurable, and the hardwired zero register is optional. Adds optional same-cycle write-to-read bypass and a sequential soft-clear engine with a busy/ready handshake. The decode stage reads operands from it; writeback writes to it.

## Interface
Parameters:
- DATA_W, 64, entry width in bits
- DEPTH, 32, number of entries, ≥2; need not be a power of two
- NREAD, 2, number of combinational read ports, ≥1
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes
- ADDR_W, $clog2(DEPTH), derived; not overridden

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- w_en  in  1  write request
- w_ready  out  1  write accepted when w_en && w_ready
- w_addr  in  ADDR_W  write address
- w_data  in  DATA_W  write data
- r_addr  in  NREAD×ADDR_W  packed read addresses; port i is r_addr[i]
- r_data  out  NREAD×DATA_W  packed read data; port i is r_data[i]
- clear_req  in  1  single-cycle pulse; starts the soft clear
- busy  out  1  clear engine active
- clear_done  out  1  one-cycle pulse when the clear completes

## Operation
- Storage: DEPTH×DATA_W flops. Every entry is 0 while reset is low.
- Write: an accepted write updates entry w_addr at the rising edge.
- Writes are dropped when:
  - w_addr ≥ DEPTH, or
  - w_addr == 0 with ZERO_REG=1.
- Read port i is combinational:
  - r_addr[i] ≥ DEPTH → 0
  - r_addr[i] == 0 with ZERO_REG=1 → 0
  - otherwise the stored value, or the bypass value (see Configuration).
- All NREAD ports are independent; identical addresses on several ports are legal.
- Clear engine states:
  - IDLE: busy=0, w_ready=1. clear_req=1 → CLEAR, ptr←0.
  - CLEAR: busy=1, w_ready=0. Each cycle entry ptr←0 and ptr←ptr+1. When ptr==DEPTH-1: clear that entry, pulse clear_done, go to IDLE.
- clear_req while busy is ignored; it does not restart the clear.
- A write presented with clear_req in IDLE is accepted in that cycle. That entry is cleared later by the engine.
- Reads during CLEAR return current contents; entries below ptr are already 0.
- Reset mid-clear: FSM → IDLE, ptr→0, all entries 0, clear_done not pulsed.

## Timing
- Reset values: w_ready=1, busy=0, clear_done=0. r_data=0 for all in-range addresses.
- Write latency: 1 cycle. Without bypass, data is readable the cycle after the accepting edge.
- Read latency: 0 cycles (combinational).
- clear_req sampled at edge T: busy=1 from T+1 to T+DEPTH inclusive. clear_done=1 during cycle T+DEPTH. busy=0, w_ready=1 at T+DEPTH+1.
- Total clear takes DEPTH cycles. The pointer never wraps; it stops at DEPTH-1.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: when an accepted write this cycle has w_addr == r_addr[i], r_data[i]=w_data in the same cycle. Bypass does not apply to out-of-range or zero-register addresses. It is inactive while busy, because no write is accepted then.
- Undefined: r_data always reflects stored contents; a read at the write address returns the old value until the next cycle.

## Structure
- Package regfile_pkg holds:
  - typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_e
  - localparam defaults RF_DATA_W=64, RF_DEPTH=32, RF_NREAD=2
- Sub-module regfile_clear_fsm holds the state register, ptr counter, busy, clear_done and w_ready. It outputs clr_we and clr_addr to the storage write mux. The clear write and an external write never coincide because w_ready=0 during CLEAR.

## Test plan
- Reset, then read all 32 entries on both ports → 0; w_ready=1, busy=0.
- Write 0xDEAD_BEEF_0000_0001 to entry 5; read entry 5 on port 1 the next cycle → that value. Write 0x1234 to entry 0 with ZERO_REG=1 → entry 0 reads 0.
- With REGFILE_BYPASS_EN, write 0xABCD to entry 7 while r_addr[0]=7 → r_data[0]=0xABCD in the same cycle. Without the macro → the old value, then 0xABCD one cycle later.
- Fill entries 1..31 with their index. Pulse clear_req at T:
  - busy is high for 32 cycles, w_en is ignored throughout, clear_done pulses at T+32.
  - At T+10, entries 0..8 read 0 and entry 20 reads 20.
  - At the end, all entries read 0.
- Second clear_req pulse at T+5 → no restart; clear_done still at T+32.
- Assert reset at T+12 mid-clear → busy=0 immediately; all entries 0; no clear_done pulse. Also with DEPTH=20: w_addr=25 write dropped, r_addr=25 reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

   typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_e;

   localparam int RF_DATA_W = 64;
   localparam int RF_DEPTH  = 32;
   localparam int RF_NREAD  = 2;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential soft-clear engine: walks a pointer over every entry, one per cycle,
// and blocks external writes while it runs.
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int DEPTH  = RF_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_req,
   output logic              busy,
   output logic              clear_done,
   output logic              w_ready,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   rf_state_e         r_state;
   rf_state_e         w_state_nxt;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] w_ptr_nxt;
   logic              w_last;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= RF_IDLE;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   assign w_last   = (r_ptr == LAST_IDX);
   assign clr_addr = r_ptr;

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      busy        = 1'b0;
      clear_done  = 1'b0;
      w_ready     = 1'b1;
      clr_we      = 1'b0;
      case (r_state)
         RF_IDLE: begin
            if (clear_req) begin
               w_state_nxt = RF_CLEAR;
               w_ptr_nxt   = '0;
            end
         end
         RF_CLEAR: begin
            busy    = 1'b1;
            w_ready = 1'b0;
            clr_we  = 1'b1;
            // Pointer parks on the last entry rather than wrapping.
            if (w_last) begin
               clear_done  = 1'b1;
               w_state_nxt = RF_IDLE;
            end else begin
               w_ptr_nxt = r_ptr + 1'b1;
            end
         end
      endcase
   end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional zero register and soft clear.
// Define REGFILE_BYPASS_EN to forward an accepted write to same-cycle reads.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int DEPTH    = RF_DEPTH,
   parameter int NREAD    = RF_NREAD,
   parameter int ZERO_REG = 1,
   parameter int ADDR_W   = $clog2(DEPTH)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          w_en,
   output logic                          w_ready,
   input  logic [ADDR_W-1:0]             w_addr,
   input  logic [DATA_W-1:0]             w_data,
   input  logic [NREAD-1:0][ADDR_W-1:0]  r_addr,
   output logic [NREAD-1:0][DATA_W-1:0]  r_data,
   input  logic                          clear_req,
   output logic                          busy,
   output logic                          clear_done
);

   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   // In range and not the hardwired zero entry.
   function automatic logic f_addr_ok(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_X) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              w_wr_acc;
   logic              w_clr_we;
   logic [ADDR_W-1:0] w_clr_addr;

   regfile_clear_fsm #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clear_fsm (
      .clk        (clk),
      .reset      (reset),
      .clear_req  (clear_req),
      .busy       (busy),
      .clear_done (clear_done),
      .w_ready    (w_ready),
      .clr_we     (w_clr_we),
      .clr_addr   (w_clr_addr)
   );

   assign w_wr_acc = w_en && w_ready && f_addr_ok(w_addr);

   // Clear and external writes are mutually exclusive since w_ready drops in CLEAR.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_clr_we) begin
         r_mem[w_clr_addr] <= '0;
      end else if (w_wr_acc) begin
         r_mem[w_addr] <= w_data;
      end
   end

   always_comb begin
      for (int unsigned p = 0; p < NREAD; p++) begin
         r_data[p] = '0;
         if (f_addr_ok(r_addr[p])) begin
            r_data[p] = r_mem[r_addr[p]];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_acc && (w_addr == r_addr[p])) begin
               r_data[p] = w_data;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default instance plus a DEPTH=20, no-zero-reg instance.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam int K_RD    = 0;
   localparam int K_BRD   = 1;
   localparam int K_WRDY  = 2;
   localparam int K_BUSY  = 3;
   localparam int K_DONE  = 4;
   localparam int K_BSTAT = 5;

   typedef struct {
      int          cyc;
      int          kind;
      int          port;
      logic [63:0] exp;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;

   logic             a_w_en, a_w_ready, a_clear_req, a_busy, a_done;
   logic [4:0]       a_w_addr;
   logic [63:0]      a_w_data;
   logic [1:0][4:0]  a_raddr;
   logic [1:0][63:0] a_rdata;

   logic             b_w_en, b_w_ready, b_clear_req, b_busy, b_done;
   logic [4:0]       b_w_addr;
   logic [15:0]      b_w_data;
   logic [0:0][4:0]  b_raddr;
   logic [0:0][15:0] b_rdata;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   regfile_mp u_dut_a (
      .clk        (clk),
      .reset      (reset),
      .w_en       (a_w_en),
      .w_ready    (a_w_ready),
      .w_addr     (a_w_addr),
      .w_data     (a_w_data),
      .r_addr     (a_raddr),
      .r_data     (a_rdata),
      .clear_req  (a_clear_req),
      .busy       (a_busy),
      .clear_done (a_done)
   );

   regfile_mp #(
      .DATA_W   (16),
      .DEPTH    (20),
      .NREAD    (1),
      .ZERO_REG (0)
   ) u_dut_b (
      .clk        (clk),
      .reset      (reset),
      .w_en       (b_w_en),
      .w_ready    (b_w_ready),
      .w_addr     (b_w_addr),
      .w_data     (b_w_data),
      .r_addr     (b_raddr),
      .r_data     (b_rdata),
      .clear_req  (b_clear_req),
      .busy       (b_busy),
      .clear_done (b_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sb.size());
      $fatal(1, "timeout");
   end

   function automatic logic [63:0] f_act(input int kind, input int port);
      case (kind)
         K_RD:    return a_rdata[port];
         K_BRD:   return {48'h0, b_rdata[0]};
         K_WRDY:  return {63'h0, a_w_ready};
         K_BUSY:  return {63'h0, a_busy};
         K_DONE:  return {63'h0, a_done};
         K_BSTAT: return {61'h0, b_w_ready, b_busy, b_done};
         default: return '1;
      endcase
   endfunction

   // Monitor: compare every expectation queued for the current cycle, away from the rising edge.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t        e;
         logic [63:0] act;
         e = sb.pop_front();
         checks++;
         if (e.cyc < cyc) begin
            errors++;
            $display("FAIL %s stale expectation for cyc %0d seen at cyc %0d", e.name, e.cyc, cyc);
         end else begin
            act = f_act(e.kind, e.port);
            if (act !== e.exp) begin
               errors++;
               $display("FAIL %s cyc=%0d got=%0h exp=%0h", e.name, cyc, act, e.exp);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int kind, input int port, input logic [63:0] v, input string nm);
      exp_t e;
      e.cyc  = cyc;
      e.kind = kind;
      e.port = port;
      e.exp  = v;
      e.name = nm;
      sb.push_back(e);
   endtask

   task automatic rd2(input int a0, input logic [63:0] e0, input int a1, input logic [63:0] e1,
                      input string tag);
      a_raddr[0] = 5'(a0);
      a_raddr[1] = 5'(a1);
      push_exp(K_RD, 0, e0, $sformatf("%s_p0_a%0d", tag, a0));
      push_exp(K_RD, 1, e1, $sformatf("%s_p1_a%0d", tag, a1));
   endtask

   task automatic status(input bit bsy, input bit done, input string tag);
      push_exp(K_BUSY, 0, {63'h0, bsy}, {tag, "_busy"});
      push_exp(K_DONE, 0, {63'h0, done}, {tag, "_done"});
      push_exp(K_WRDY, 0, {63'h0, !bsy}, {tag, "_wready"});
   endtask

   task automatic wr_a(input int a, input logic [63:0] d);
      a_w_en   = 1'b1;
      a_w_addr = 5'(a);
      a_w_data = d;
   endtask

   initial begin
      int tc;
      a_w_en = 0; a_w_addr = '0; a_w_data = '0; a_raddr = '0; a_clear_req = 0;
      b_w_en = 0; b_w_addr = '0; b_w_data = '0; b_raddr = '0; b_clear_req = 0;

      // Reset state
      step();
      rd2(5, 64'h0, 31, 64'h0, "rst");
      status(1'b0, 1'b0, "rst");
      push_exp(K_BSTAT, 0, 64'h4, "rst_b_status");
      step();
      reset = 1'b1;
      step();

      for (int a = 0; a < 32; a++) begin
         rd2(a, 64'h0, a, 64'h0, "init");
         step();
      end

      // Write / read-after-write, zero register
      wr_a(5, 64'hDEAD_BEEF_0000_0001);
      rd2(0, 64'h0, 5, BYP ? 64'hDEAD_BEEF_0000_0001 : 64'h0, "w5_same");
      step();
      a_w_en = 0;
      rd2(0, 64'h0, 5, 64'hDEAD_BEEF_0000_0001, "w5_next");
      step();
      wr_a(0, 64'h1234);
      rd2(0, 64'h0, 5, 64'hDEAD_BEEF_0000_0001, "w0_same");
      step();
      a_w_en = 0;
      rd2(0, 64'h0, 0, 64'h0, "w0_next");
      step();

      // Bypass vs registered read
      wr_a(7, 64'hABCD);
      rd2(7, BYP ? 64'hABCD : 64'h0, 6, 64'h0, "byp_same");
      step();
      a_w_en = 0;
      rd2(7, 64'hABCD, 6, 64'h0, "byp_next");
      step();

      // DEPTH=20 instance: out-of-range write dropped, out-of-range read is 0
      b_w_en = 1; b_w_addr = 5'd25; b_w_data = 16'h5555; b_raddr[0] = 5'd25;
      push_exp(K_BRD, 0, 64'h0, "b_oor_same");
      step();
      b_w_addr = 5'd19; b_w_data = 16'h1919; b_raddr[0] = 5'd25;
      push_exp(K_BRD, 0, 64'h0, "b_oor_next");
      step();
      b_w_addr = 5'd0; b_w_data = 16'h00AA; b_raddr[0] = 5'd19;
      push_exp(K_BRD, 0, 64'h1919, "b_last_entry");
      step();
      b_w_en = 0; b_raddr[0] = 5'd0;
      push_exp(K_BRD, 0, 64'h00AA, "b_entry0_writable");
      step();
      b_raddr[0] = 5'd9;
      push_exp(K_BRD, 0, 64'h0, "b_no_alias");
      push_exp(K_BSTAT, 0, 64'h4, "b_status");
      step();

      // Fill 1..31 with their index
      for (int a = 1; a < 32; a++) begin
         wr_a(a, 64'(a));
         step();
      end
      a_w_en = 0;
      rd2(20, 64'd20, 31, 64'd31, "fill");
      step();

      // Clear 1: write accepted alongside clear_req, writes ignored while busy
      tc = cyc;
      a_clear_req = 1;
      wr_a(3, 64'h99);
      status(1'b0, 1'b0, "clr1_k0");
      step();
      a_clear_req = 0;
      wr_a(30, 64'hFFFF);
      for (int k = 1; k <= 33; k++) begin
         if (k == 33) a_w_en = 0;
         status(k <= 32, k == 32, $sformatf("clr1_k%0d", k));
         if (k == 1)  rd2(3, 64'h99, 30, 64'd30, "clr1_k1");
         if (k == 10) rd2(8, 64'h0, 20, 64'd20, "clr1_k10");
         if (k == 11) rd2(9, 64'h0, 10, 64'd10, "clr1_k11");
         if (k == 20) rd2(30, 64'd30, 18, 64'h0, "clr1_k20");
         step();
      end
      for (int a = 0; a < 32; a++) begin
         rd2(a, 64'h0, 31 - a, 64'h0, "clr1_end");
         step();
      end

      // Clear 2: second request while busy does not restart
      wr_a(31, 64'h31);
      step();
      a_w_en = 0;
      tc = cyc;
      a_clear_req = 1;
      step();
      a_clear_req = 0;
      for (int k = 1; k <= 33; k++) begin
         a_clear_req = (k == 5);
         status(k <= 32, k == 32, $sformatf("clr2_k%0d", k));
         if (k == 32) rd2(31, 64'h31, 0, 64'h0, "clr2_k32");
         if (k == 33) rd2(31, 64'h0, 0, 64'h0, "clr2_k33");
         step();
      end

      // Clear 3: reset asserted mid-clear
      wr_a(15, 64'h15);
      step();
      wr_a(31, 64'h31);
      step();
      a_w_en = 0;
      tc = cyc;
      a_clear_req = 1;
      step();
      a_clear_req = 0;
      for (int k = 1; k <= 11; k++) begin
         status(1'b1, 1'b0, $sformatf("clr3_k%0d", k));
         step();
      end
      reset = 1'b0;
      status(1'b0, 1'b0, "clr3_rst");
      rd2(15, 64'h0, 31, 64'h0, "clr3_rst");
      step();
      reset = 1'b1;
      for (int k = 13; k <= 40; k++) begin
         status(1'b0, 1'b0, $sformatf("clr3_k%0d", k));
         if (k == 13) rd2(15, 64'h0, 31, 64'h0, "clr3_after");
         step();
      end

      repeat (3) step();
      if (sb.size() != 0) begin
         checks += sb.size();
         errors += sb.size();
         $display("FAIL scoreboard_drain got=%0d pending exp=0 (tc=%0d)", sb.size(), tc);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
